// File: rtl/mmio_pkg.sv
// Shared types and helpers for the MMIO interconnect.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DECODE  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_t;

  // Bit offset of slave idx within the flattened s_rdata bus.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mmio_interconnect_bus_timeout.sv
// Access watchdog: counts cycles while enabled, flags the cycle whose
// increment would bring the count to TIMEOUT.
module bus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Expired is combinational so the owner can leave on the TIMEOUT-th
  // waiting cycle instead of one cycle later.
  assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

  // Cycle counter with synchronous clear and async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mmio_interconnect.sv
// CPU data port to NUM_SLAVES memory-mapped peripherals: address decode,
// req/ready handshake, read-data return, decode and timeout errors.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SEL_HI     = 31,
  parameter int SEL_LO     = 28,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_req,
  input  logic                         m_rw,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_ready,
  output logic                         m_err,
  output logic                         busy,
  output logic [NUM_SLAVES-1:0]        s_req,
  output logic                         s_rw,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready
);

  localparam int SEL_W = SEL_HI - SEL_LO + 1;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  state_t             state;
  err_t               err_q;
  logic [IDX_W-1:0]   idx_q;
  logic [SEL_W-1:0]   sel_field;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_ok;
  logic               expired;
  logic [DATA_W-1:0]  rdata_arr [NUM_SLAVES];

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slice
    assign rdata_arr[g] = s_rdata[slice_lo(g, DATA_W) +: DATA_W];
  end

  // Decode the slave index from the live master address.
  always_comb begin
    sel_field = m_addr[SEL_HI:SEL_LO];
    sel_ok    = 32'(sel_field) < 32'(NUM_SLAVES);
    sel_idx   = IDX_W'(sel_field);
  end

  bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_ACCESS),
    .enable  (state == ST_ACCESS),
    .expired (expired)
  );

  // Access FSM with all master/slave outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      err_q   <= ERR_NONE;
      idx_q   <= '0;
      s_req   <= '0;
      s_rw    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      m_rdata <= '0;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          m_ready <= 1'b0;
          m_err   <= 1'b0;
          if (m_req) begin
            busy <= 1'b1;
            if (sel_ok) begin
              idx_q   <= sel_idx;
              s_addr  <= m_addr;
              s_wdata <= m_wdata;
              s_rw    <= m_rw;
              s_req   <= NUM_SLAVES'(1) << sel_idx;
              err_q   <= ERR_NONE;
              state   <= ST_ACCESS;
            end else begin
              err_q   <= ERR_DECODE;
              m_rdata <= '0;
              state   <= ST_DONE;
            end
          end
        end
        ST_ACCESS: begin
          // Ready is tested first so it wins over a same-cycle timeout.
          if (s_ready[idx_q]) begin
            if (!s_rw) begin
              m_rdata <= rdata_arr[idx_q];
            end
            s_req <= '0;
            err_q <= ERR_NONE;
            state <= ST_DONE;
          end else if (expired) begin
            s_req   <= '0;
            err_q   <= ERR_TIMEOUT;
            m_rdata <= '0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          m_ready <= 1'b1;
          m_err   <= (err_q != ERR_NONE);
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed, table-driven bench for mmio_interconnect (4 slaves, TIMEOUT=8).
module tb_mmio_interconnect;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic             clk;
  logic             rst;
  logic             m_req;
  logic             m_rw;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic [DW-1:0]    m_rdata;
  logic             m_ready;
  logic             m_err;
  logic             busy;
  logic [NS-1:0]    s_req;
  logic             s_rw;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]    s_ready;

  int n_pass  = 0;
  int n_total = 0;

  mmio_interconnect #(
    .NUM_SLAVES (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .SEL_HI     (31),
    .SEL_LO     (28),
    .TIMEOUT    (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_rw    (m_rw),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .m_err   (m_err),
    .busy    (busy),
    .s_req   (s_req),
    .s_rw    (s_rw),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .s_ready (s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;     // s_req cycle on which the slave answers, 0 = never
    logic [3:0]  exp_sreq;
    int          exp_cyc;   // cycles s_req is high
    int          exp_lat;   // cycle of m_ready, request in cycle 0
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Master drives one request; bench slave answers after `delay` s_req cycles,
  // while every non-selected slave (and all slaves outside ACCESS) assert ready.
  task automatic run_access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                            input int delay, output int lat, output int cyc_cnt,
                            output logic [3:0] seen, output logic [31:0] rdata,
                            output logic err, output logic lat_ok, output logic busy_ok,
                            output logic done);
    lat = 0; cyc_cnt = 0; seen = '0; rdata = '0; err = 1'b0;
    lat_ok = 1'b1; busy_ok = 1'b1; done = 1'b0;
    m_req = 1'b1; m_rw = rw; m_addr = addr; m_wdata = wdata;
    for (int c = 1; c <= 60 && !done; c++) begin
      tick();
      s_ready = '0;
      if (m_ready) begin
        lat = c; rdata = m_rdata; err = m_err;
        if (busy) busy_ok = 1'b0;
        m_req = 1'b0;
        done = 1'b1;
      end else begin
        if (!busy) busy_ok = 1'b0;
        if (s_req != '0) begin
          cyc_cnt++;
          seen = seen | s_req;
          if (s_addr != addr || s_wdata != wdata || s_rw != rw) lat_ok = 1'b0;
          m_addr = ~addr; m_wdata = ~wdata; m_rw = ~rw;
          s_ready = (cyc_cnt == delay) ? s_req : ~s_req;
        end else begin
          s_ready = '1;
        end
      end
    end
    m_req = 1'b0;
    s_ready = '0;
  endtask

  task automatic apply_vec(input int i, input vec_t v);
    int lat, cyc;
    logic [3:0] seen;
    logic [31:0] rdata;
    logic err, lat_ok, busy_ok, done;
    run_access(v.rw, v.addr, v.wdata, v.delay, lat, cyc, seen, rdata, err, lat_ok, busy_ok, done);
    check($sformatf("v%0d_completed", i), 64'(done), 64'(1));
    check($sformatf("v%0d_sreq", i), 64'(seen), 64'(v.exp_sreq));
    check($sformatf("v%0d_sreq_cycles", i), 64'(cyc), 64'(v.exp_cyc));
    check($sformatf("v%0d_latency", i), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d_err", i), 64'(err), 64'(v.exp_err));
    check($sformatf("v%0d_rdata", i), 64'(rdata), 64'(v.exp_rdata));
    check($sformatf("v%0d_latched", i), 64'(lat_ok), 64'(1));
    check($sformatf("v%0d_busy", i), 64'(busy_ok), 64'(1));
    tick();
    check($sformatf("v%0d_ready_pulse", i), 64'({m_ready, busy, s_req}), 64'(0));
  endtask

  initial begin
    int strays;

    vecs[0] = '{1'b0, 32'h1000_0004, 32'h0000_0000, 1, 4'b0010, 1, 3,  1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h3000_0010, 32'h0000_0055, 5, 4'b1000, 5, 7,  1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h7000_0000, 32'h0000_0000, 1, 4'b0000, 0, 2,  1'b1, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'h2000_0000, 32'h0000_0000, 0, 4'b0100, 8, 10, 1'b1, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 1, 4'b0001, 1, 3,  1'b0, 32'h1111_0000};
    vecs[5] = '{1'b0, 32'h3000_0000, 32'h0000_0000, 8, 4'b1000, 8, 10, 1'b0, 32'h3333_3333};
    vecs[6] = '{1'b1, 32'h2000_0020, 32'h0000_CAFE, 2, 4'b0100, 2, 4,  1'b0, 32'h3333_3333};
    vecs[7] = '{1'b0, 32'h4000_0000, 32'h0000_0000, 1, 4'b0000, 0, 2,  1'b1, 32'h0000_0000};
    vecs[8] = '{1'b0, 32'h3FFF_FFFC, 32'h1234_5678, 3, 4'b1000, 3, 5,  1'b0, 32'h3333_3333};

    rst = 1'b0; m_req = 1'b0; m_rw = 1'b0; m_addr = '0; m_wdata = '0; s_ready = '0;
    s_rdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_0000};

    #2 rst = 1'b1;
    #1;
    check("reset_ctrl", 64'({m_ready, m_err, busy, s_req, s_rw}), 64'(0));
    check("reset_rdata", 64'(m_rdata), 64'(0));
    check("reset_addr_wdata", {s_addr, s_wdata}, 64'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) apply_vec(i, vecs[i]);

    // Reset while an access is outstanding.
    m_req = 1'b1; m_rw = 1'b0; m_addr = 32'h2000_0000;
    tick();
    check("pre_rst_sreq", 64'({busy, s_req}), 64'(5'b1_0100));
    m_req = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_access", 64'({m_ready, busy, s_req}), 64'(0));
    check("rst_mid_rdata", 64'(m_rdata), 64'(0));
    tick();
    rst = 1'b0;
    strays = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (m_ready || busy || s_req != '0) strays++;
    end
    check("no_stray_after_rst", 64'(strays), 64'(0));

    apply_vec(9, '{1'b0, 32'h1000_0000, 32'h0000_0000, 1, 4'b0010, 1, 3, 1'b0, 32'hDEAD_BEEF});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
